// File: rtl/rfid_access_scheduler.sv
// rfid_access_scheduler
//   Sequences the CR95HF RFID front end. It issues periodic scan requests and waits a bounded
//   time for each reply. A permitted card opens a timed firewall unlock window. Repeated denials
//   put the block into a timed lockout.
//
// Ports
//   clk, rst_n     system clock, asynchronous active-low reset
//   enable         1 = scheduling active; 0 = drain back to idle, issue no new scans
//   scan_start     one-cycle pulse requesting one reader transaction
//   scan_done      one-cycle pulse, reader transaction complete
//   scan_valid     permission result (qualified by scan_done)
//   scan_uid       card UID (qualified by scan_done)
//   clear_lockout  one-cycle admin pulse clearing lockout and the fail count
//   unlock         firewall unlock window (level)
//   unlock_uid     UID that opened the current/last window
//   deny_pulse     one-cycle pulse per denied card
//   timeout_pulse  one-cycle pulse when a scan is abandoned
//   locked         lockout active
//   fail_count     consecutive denials since the last grant/clear
module rfid_access_scheduler #(
  parameter int unsigned SCAN_PERIOD    = 50000,
  parameter int unsigned RESP_TIMEOUT   = 20000,
  parameter int unsigned GRANT_CYCLES   = 1000000,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 5000000,
  parameter int unsigned CNT_W          = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        scan_start,
  input  logic        scan_done,
  input  logic        scan_valid,
  input  logic [31:0] scan_uid,
  input  logic        clear_lockout,
  output logic        unlock,
  output logic [31:0] unlock_uid,
  output logic        deny_pulse,
  output logic        timeout_pulse,
  output logic        locked,
  output logic [3:0]  fail_count
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitPeriod,
    StWaitResult,
    StEval,
    StGrant,
    StLockout
  } state_e;

  // Timer reload values: a load of N-1 gives N cycles in the entered state.
  localparam logic [CNT_W-1:0] LdScan  = CNT_W'(SCAN_PERIOD - 1);
  localparam logic [CNT_W-1:0] LdResp  = CNT_W'(RESP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LdGrant = CNT_W'(GRANT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LdLock  = CNT_W'(LOCKOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic               valid_q, valid_d;
  logic [31:0]        uid_q, uid_d;
  logic [31:0]        unlock_uid_q, unlock_uid_d;
  logic [3:0]         fail_q, fail_d;
  logic [3:0]         fail_inc;
  logic               timer_zero;

  assign timer_zero = (timer_q == '0);
  assign fail_inc   = (fail_q == 4'hF) ? 4'hF : fail_q + 4'd1;

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_zero ? '0 : timer_q - CNT_W'(1);
    valid_d       = valid_q;
    uid_d         = uid_q;
    unlock_uid_d  = unlock_uid_q;
    fail_d        = fail_q;
    scan_start    = 1'b0;
    deny_pulse    = 1'b0;
    timeout_pulse = 1'b0;

    case (state_q)
      StIdle: begin
        if (enable) begin
          timer_d = LdScan;
          state_d = StWaitPeriod;
        end
      end
      StWaitPeriod: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (timer_zero) begin
          scan_start = 1'b1;
          timer_d    = LdResp;
          state_d    = StWaitResult;
        end
      end
      StWaitResult: begin
        // A reply on the final timer cycle still counts; enable is ignored so the
        // outstanding transaction always completes.
        if (scan_done) begin
          valid_d = scan_valid;
          uid_d   = scan_uid;
          state_d = StEval;
        end else if (timer_zero) begin
          timeout_pulse = 1'b1;
          state_d       = StIdle;
        end
      end
      StEval: begin
        if (valid_q) begin
          unlock_uid_d = uid_q;
          fail_d       = 4'd0;
          timer_d      = LdGrant;
          state_d      = StGrant;
        end else begin
          deny_pulse = 1'b1;
          fail_d     = fail_inc;
          if (32'(fail_inc) >= MAX_FAILS) begin
            timer_d = LdLock;
            state_d = StLockout;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StGrant: begin
        if (!enable || timer_zero) state_d = StIdle;
      end
      StLockout: begin
        if (timer_zero) begin
          fail_d  = 4'd0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Admin clear wins over a lockout in progress and over a denial that would start one.
    if (clear_lockout) begin
      fail_d = 4'd0;
      if (state_q == StLockout || state_d == StLockout) state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      valid_q      <= 1'b0;
      uid_q        <= '0;
      unlock_uid_q <= '0;
      fail_q       <= 4'd0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      valid_q      <= valid_d;
      uid_q        <= uid_d;
      unlock_uid_q <= unlock_uid_d;
      fail_q       <= fail_d;
    end
  end

  // Decoded from state so an asynchronous reset drops them immediately.
  assign unlock     = (state_q == StGrant);
  assign locked     = (state_q == StLockout);
  assign unlock_uid = unlock_uid_q;
  assign fail_count = fail_q;

endmodule

// File: tb/tb_rfid_access_scheduler.sv
module tb_rfid_access_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        scan_start;
  logic        scan_done = 1'b0;
  logic        scan_valid = 1'b0;
  logic [31:0] scan_uid = '0;
  logic        clear_lockout = 1'b0;
  logic        unlock;
  logic [31:0] unlock_uid;
  logic        deny_pulse;
  logic        timeout_pulse;
  logic        locked;
  logic [3:0]  fail_count;

  int checks = 0;
  int errors = 0;

  localparam int SigScan    = 0;
  localparam int SigTimeout = 1;
  localparam int SigUnlock  = 2;
  localparam int SigLocked  = 3;

  rfid_access_scheduler #(
    .SCAN_PERIOD   (8),
    .RESP_TIMEOUT  (6),
    .GRANT_CYCLES  (10),
    .MAX_FAILS     (3),
    .LOCKOUT_CYCLES(20),
    .CNT_W         (24)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .scan_start   (scan_start),
    .scan_done    (scan_done),
    .scan_valid   (scan_valid),
    .scan_uid     (scan_uid),
    .clear_lockout(clear_lockout),
    .unlock       (unlock),
    .unlock_uid   (unlock_uid),
    .deny_pulse   (deny_pulse),
    .timeout_pulse(timeout_pulse),
    .locked       (locked),
    .fail_count   (fail_count)
  );

  always #5 clk = ~clk;

  function automatic logic sig(input int sel);
    case (sel)
      SigScan:    return scan_start;
      SigTimeout: return timeout_pulse;
      SigUnlock:  return unlock;
      default:    return locked;
    endcase
  endfunction

  // Counts falling edges until the selected output is high; n = -1 if the bound expires.
  task automatic wait_for(input int sel, output int n);
    bit found = 0;
    n = -1;
    for (int i = 1; i <= 200 && !found; i++) begin
      @(negedge clk);
      if (sig(sel) === 1'b1) begin
        n = i;
        found = 1;
      end
    end
  endtask

  // Replies to the scan_start seen at the current falling edge; returns in the EVAL cycle.
  task automatic answer(input logic v, input logic [31:0] u);
    @(negedge clk);
    scan_done  = 1'b1;
    scan_valid = v;
    scan_uid   = u;
    @(negedge clk);
    scan_done  = 1'b0;
    scan_valid = 1'b0;
  endtask

  task automatic respond(input logic v, input logic [31:0] u, input string tag);
    int n;
    wait_for(SigScan, n);
    checks++;
    if (n < 0) begin
      errors++;
      $display("FAIL %s_scan_wait: no scan_start within bound", tag);
    end
    answer(v, u);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({scan_start, unlock, deny_pulse, timeout_pulse, locked} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000",
               {scan_start, unlock, deny_pulse, timeout_pulse, locked});
    end
    checks++;
    if (unlock_uid !== 32'h0) begin
      errors++;
      $display("FAIL reset_uid: got %h want 00000000", unlock_uid);
    end
    checks++;
    if (fail_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_fail_count: got %0d want 0", fail_count);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (scan_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_no_scan: got %b want 0", scan_start);
    end
  endtask

  task automatic test_timeout;
    int n;
    enable = 1'b1;
    wait_for(SigScan, n);
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL to_first_scan: got %0d cycles want 8", n);
    end
    @(negedge clk);
    checks++;
    if (scan_start !== 1'b0) begin
      errors++;
      $display("FAIL to_scan_width: got %b want 0", scan_start);
    end
    wait_for(SigTimeout, n);
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL to_timeout: got %0d cycles after scan+1 want 5", n);
    end
    checks++;
    if (fail_count !== 4'd0) begin
      errors++;
      $display("FAIL to_fail_count: got %0d want 0", fail_count);
    end
    // Eight idle cycles follow the timeout (one IDLE + seven timer), scan on the ninth.
    wait_for(SigScan, n);
    checks++;
    if (n !== 9) begin
      errors++;
      $display("FAIL to_next_scan: got %0d cycles want 9", n);
    end
  endtask

  task automatic test_grant;
    int n;
    bit stray;
    respond(1'b1, 32'hB364DE05, "grant");
    checks++;
    if (unlock !== 1'b0) begin
      errors++;
      $display("FAIL grant_eval_unlock: got %b want 0", unlock);
    end
    @(negedge clk);
    checks++;
    if (unlock !== 1'b1) begin
      errors++;
      $display("FAIL grant_latency: unlock got %b want 1 two cycles after scan_done", unlock);
    end
    checks++;
    if (unlock_uid !== 32'hB364DE05) begin
      errors++;
      $display("FAIL grant_uid: got %h want b364de05", unlock_uid);
    end
    checks++;
    if (fail_count !== 4'd0) begin
      errors++;
      $display("FAIL grant_fail_count: got %0d want 0", fail_count);
    end
    n = 0;
    stray = 0;
    while (unlock === 1'b1 && n < 100) begin
      n++;
      if (scan_start !== 1'b0) stray = 1;
      @(negedge clk);
    end
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL grant_window: got %0d cycles want 10", n);
    end
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL grant_no_scan: got scan_start during window want none");
    end
  endtask

  task automatic deny_step(input logic [3:0] want_cnt, input logic want_lock, input string tag);
    respond(1'b0, 32'h1234_0000 + 32'(want_cnt), tag);
    checks++;
    if (deny_pulse !== 1'b1) begin
      errors++;
      $display("FAIL %s_deny: got %b want 1", tag, deny_pulse);
    end
    @(negedge clk);
    checks++;
    if (fail_count !== want_cnt || locked !== want_lock) begin
      errors++;
      $display("FAIL %s_count: got cnt=%0d locked=%b want cnt=%0d locked=%b",
               tag, fail_count, locked, want_cnt, want_lock);
    end
  endtask

  task automatic test_lockout;
    int n;
    bit stray;
    deny_step(4'd1, 1'b0, "lock1");
    deny_step(4'd2, 1'b0, "lock2");
    deny_step(4'd3, 1'b1, "lock3");
    n = 0;
    stray = 0;
    while (locked === 1'b1 && n < 100) begin
      n++;
      if (scan_start !== 1'b0) stray = 1;
      @(negedge clk);
    end
    checks++;
    if (n !== 20) begin
      errors++;
      $display("FAIL lock_duration: got %0d cycles want 20", n);
    end
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL lock_no_scan: got scan_start while locked want none");
    end
    checks++;
    if (fail_count !== 4'd0) begin
      errors++;
      $display("FAIL lock_end_count: got %0d want 0", fail_count);
    end
    wait_for(SigScan, n);
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL lock_resume: got %0d cycles want 8", n);
    end
  endtask

  task automatic test_deny_then_grant;
    int n;
    deny_step(4'd1, 1'b0, "mix1");
    deny_step(4'd2, 1'b0, "mix2");
    respond(1'b1, 32'hCAFE0001, "mix3");
    @(negedge clk);
    checks++;
    if (unlock !== 1'b1 || locked !== 1'b0 || fail_count !== 4'd0) begin
      errors++;
      $display("FAIL mix_grant: got unlock=%b locked=%b cnt=%0d want 1 0 0",
               unlock, locked, fail_count);
    end
    checks++;
    if (unlock_uid !== 32'hCAFE0001) begin
      errors++;
      $display("FAIL mix_uid: got %h want cafe0001", unlock_uid);
    end
    n = 0;
    while (unlock === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_clear;
    int n;
    deny_step(4'd1, 1'b0, "clr1");
    deny_step(4'd2, 1'b0, "clr2");
    deny_step(4'd3, 1'b1, "clr3");
    repeat (2) @(negedge clk);
    clear_lockout = 1'b1;
    @(negedge clk);
    clear_lockout = 1'b0;
    checks++;
    if (locked !== 1'b0 || fail_count !== 4'd0) begin
      errors++;
      $display("FAIL clr_release: got locked=%b cnt=%0d want 0 0", locked, fail_count);
    end
    wait_for(SigScan, n);
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL clr_resume: got %0d cycles want 8", n);
    end
    // Clear coincident with the lockout-triggering denial.
    answer(1'b0, 32'hDEAD0001);
    @(negedge clk);
    deny_step(4'd2, 1'b0, "clr5");
    respond(1'b0, 32'hDEAD0003, "clr6");
    clear_lockout = 1'b1;
    checks++;
    if (deny_pulse !== 1'b1) begin
      errors++;
      $display("FAIL clr_same_deny: got %b want 1", deny_pulse);
    end
    @(negedge clk);
    clear_lockout = 1'b0;
    checks++;
    if (locked !== 1'b0 || fail_count !== 4'd0) begin
      errors++;
      $display("FAIL clr_same_cycle: got locked=%b cnt=%0d want 0 0", locked, fail_count);
    end
  endtask

  task automatic test_reset_mid_grant;
    int n;
    respond(1'b1, 32'h0BADF00D, "rst");
    repeat (3) @(negedge clk);
    checks++;
    if (unlock !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_unlock: got %b want 1", unlock);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (unlock !== 1'b0 || locked !== 1'b0 || unlock_uid !== 32'h0) begin
      errors++;
      $display("FAIL rst_async: got unlock=%b locked=%b uid=%h want 0 0 0",
               unlock, locked, unlock_uid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_for(SigScan, n);
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL rst_first_scan: got %0d cycles want 8", n);
    end
    wait_for(SigTimeout, n);
    checks++;
    if (n !== 6) begin
      errors++;
      $display("FAIL rst_timeout: got %0d cycles want 6", n);
    end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_grant();
    test_lockout();
    test_deny_then_grant();
    test_clear();
    test_reset_mid_grant();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
